// File: rtl/move_seq_pkg.sv
// Shared encodings and defaults for the move_sequencer closed-loop driver.
package move_seq_pkg;

  localparam int STATE_W_DEF = 3;
  localparam int TIMEOUT_DEF = 15;
  localparam int SETTLE_DEF  = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_MOVE   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CHECK  = ST_CHECK,
    S_MOVE   = ST_MOVE,
    S_SETTLE = ST_SETTLE,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } state_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter loaded on MOVE exit; expired_o is high once SETTLE cycles have elapsed.
module settle_timer
  import move_seq_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = cnt_w(SETTLE);
  localparam logic [TW-1:0] LOAD_VAL = TW'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/move_sequencer.sv
// Pulses move until state_in equals the latched target or the move budget runs out.
// States: IDLE wait req | CHECK compare/budget | MOVE pulse | SETTLE wait | DONE/ERR one-cycle result.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SETTLE  = SETTLE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic [STATE_W-1:0]          target,
  input  logic [STATE_W-1:0]          state_in,
  output logic                        move,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [cnt_w(TIMEOUT)-1:0]   moves_used
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_e             state_q, state_d;
  logic [STATE_W-1:0] tgt_q, tgt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               move_q, busy_q, done_q, err_q;
  logic               settle_exp;

  settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk       (clk),
    .reset     (reset),
    .load_i    (state_q == S_MOVE),
    .en_i      (state_q == S_SETTLE),
    .expired_o (settle_exp)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          tgt_d   = target;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (state_in == tgt_q)    state_d = S_DONE;
        else if (cnt_q == CNT_MAX) state_d = S_ERR;
        else                       state_d = S_MOVE;
      end
      S_MOVE: begin
        cnt_d   = cnt_q + CW'(1);
        // With no settle time the next compare follows the pulse directly.
        state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        if (settle_exp) state_d = S_CHECK;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      move_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      move_q  <= (state_d == S_MOVE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign move       = move_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign moves_used = cnt_q;

endmodule
